// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU channel widths plus the initiator's state encoding and request payload.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } apu_init_state_e;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_payload_t;

endpackage

// File: rtl/cv32e40n_apu_tag_fifo.sv
// In-order tag FIFO for granted APU operations; push and pop may share a cycle when non-empty.
module cv32e40n_apu_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cv32e40n_apu_initiator.sv
// Core-side APU requester: holds one request until grant, tracks granted ops in order and
// returns each result with its tag. Handshake: issue transfers when issue_valid_i && issue_ready_o.
module cv32e40n_apu_initiator
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]     issue_operands_i,
  input  logic [APU_WOP_CPU-1:0]             issue_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]        issue_flags_i,
  input  logic [TAG_W-1:0]                   issue_tag_i,
  output logic                               apu_req_o,
  output logic [APU_NARGS_CPU-1:0][31:0]     apu_operands_o,
  output logic [APU_WOP_CPU-1:0]             apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]        apu_flags_o,
  input  logic                               apu_gnt_i,
  input  logic                               apu_rvalid_i,
  input  logic [31:0]                        apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]        apu_flags_i,
  output logic                               res_valid_o,
  output logic [31:0]                        res_data_o,
  output logic [APU_NUSFLAGS_CPU-1:0]        res_flags_o,
  output logic [TAG_W-1:0]                   res_tag_o,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_REQ  = REQ;

  logic [0:0]       state_q;
  apu_req_payload_t payload_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] outstanding;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             grant;
  logic             pop;

  assign issue_ready_o = (state_q == S_IDLE) && !fifo_full;
  assign accept        = issue_valid_i && issue_ready_o;
  assign grant         = (state_q == S_REQ) && apu_gnt_i;
  // The FIFO count is registered, so a grant in this cycle cannot satisfy this cycle's rvalid.
  assign pop           = apu_rvalid_i && !fifo_empty;

  assign apu_req_o      = (state_q == S_REQ);
  assign apu_operands_o = payload_q.operands;
  assign apu_op_o       = payload_q.op;
  assign apu_flags_o    = payload_q.flags;
  assign busy_o         = apu_req_o || (outstanding != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      payload_q <= '0;
      tag_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q            <= S_REQ;
            payload_q.operands <= issue_operands_i;
            payload_q.op       <= issue_op_i;
            payload_q.flags    <= issue_flags_i;
            tag_q              <= issue_tag_i;
          end
        end
        S_REQ: begin
          if (apu_gnt_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  cv32e40n_apu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (tag_q),
    .pop_i   (pop),
    .data_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_flags_o <= '0;
      res_tag_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      res_valid_o <= pop;
      if (pop) begin
        res_data_o  <= apu_result_i;
        res_flags_o <= apu_flags_i;
        res_tag_o   <= head_tag;
      end
      // A result with nothing previously granted is a responder protocol violation.
      if (apu_rvalid_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cv32e40n_apu_initiator.md
Name: cv32e40n_apu_initiator

Overview:
Requester side of the core↔APU request/response channel. It accepts operations from the core issue stage over a valid/ready port and drives apu_req/operands/op/flags until the APU grants. It tracks in-order outstanding operations with a tag FIFO and returns each APU result to the core with its tag. It sits between the EX-stage offload logic and any APU responder, including cv32e40n_apu_dummy.

Parameters:
MAX_OUTSTANDING, 2, maximum number of granted operations awaiting rvalid (1..8).
TAG_W, 5, width of the core-side tag (destination register index) carried per operation.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  core offers an operation
issue_ready_o  out  1  initiator accepts the operation this cycle
issue_operands_i  in  APU_NARGS_CPU x 32  operands
issue_op_i  in  APU_WOP_CPU  opcode
issue_flags_i  in  APU_NDSFLAGS_CPU  downstream flags
issue_tag_i  in  TAG_W  tag returned with the result
apu_req_o  out  1  request to APU
apu_operands_o  out  APU_NARGS_CPU x 32  registered operands
apu_op_o  out  APU_WOP_CPU  registered opcode
apu_flags_o  out  APU_NDSFLAGS_CPU  registered flags
apu_gnt_i  in  1  APU grant
apu_rvalid_i  in  1  APU result valid (single-cycle pulse)
apu_result_i  in  32  APU result
apu_flags_i  in  APU_NUSFLAGS_CPU  upstream flags
res_valid_o  out  1  result pulse to core
res_data_o  out  32  result
res_flags_o  out  APU_NUSFLAGS_CPU  result flags
res_tag_o  out  TAG_W  tag of the completed operation
busy_o  out  1  state REQ or outstanding != 0
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_ni=0): state IDLE; apu_req_o=0; apu_operands/op/flags_o=0; outstanding=0; tag FIFO empty; res_valid_o=0; res_data/flags/tag_o=0; err_o=0; busy_o=0. Reset mid-request or mid-flight discards everything, with no response to the core.
- FSM states: IDLE and REQ.
- IDLE: issue_ready_o = (outstanding < MAX_OUTSTANDING). If issue_valid_i && issue_ready_o: latch operands/op/flags/tag into request registers and go to REQ.
- REQ: apu_req_o=1 and issue_ready_o=0. Payload outputs hold stable until grant.
  - apu_gnt_i=1: handshake. Push the latched tag, outstanding+1, go to IDLE next cycle.
  - apu_gnt_i=0: stay in REQ, payload unchanged.
- apu_req_o is driven only from the register, never combinationally from issue_valid_i.
- Latency: accept at cycle N → apu_req_o at N+1. Earliest re-accept is the cycle after the grant, so at most one request per 2 cycles.
- apu_rvalid_i=1 with outstanding>0 (counting only grants from earlier cycles): pop the FIFO head, outstanding−1, register result/flags/tag.
  - res_valid_o=1 for exactly one cycle, the cycle after rvalid.
  - No backpressure; the core must sink the result.
- Grant and rvalid in the same cycle: push and pop both happen; outstanding is unchanged; rvalid belongs to the oldest previously granted operation.
- rvalid with no previously granted operation: ignored (no pop, no res_valid_o), err_o set to 1 and held until reset.
- apu_gnt_i while in IDLE: ignored. Grant outside a request is legal for responders.
- Tag FIFO: depth MAX_OUTSTANDING, in-order. Full occurs only at outstanding==MAX, which issue_ready_o already blocks. Pointers wrap modulo depth.
- outstanding counter width: $clog2(MAX_OUTSTANDING+1).
- res_data/flags/tag_o keep their last value when res_valid_o=0.

Decomposition:
- Payload widths (APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU) come from cv32e40p_apu_core_pkg.
- Add to that package:
  - the initiator state enum apu_init_state_e {IDLE, REQ};
  - a packed apu_req_payload_t struct (operands, op, flags).
- Sub-module cv32e40n_apu_tag_fifo: parameterised depth/width, push/pop/full/empty. It permits push and pop in the same cycle when non-empty.

Test Plan:
- Against cv32e40n_apu_dummy: issue op=3, tag=7 at cycle 0 → apu_req_o=1 at cycle 1 with gnt, rvalid at cycle 2, res_valid_o=1 with res_tag_o=7 and res_data_o=0 at cycle 3, busy_o=0 at cycle 4.
- Grant withheld 5 cycles → apu_req_o stays 1 and operands/op/flags are unchanged over all 5 cycles; issue_ready_o=0 throughout.
- MAX_OUTSTANDING=2, responder grants immediately and withholds rvalid:
  - two ops granted → issue_ready_o=0;
  - first rvalid → issue_ready_o=1 next cycle;
  - tags return in issue order (3 then 9).
- Grant and rvalid in the same cycle with outstanding=1 → outstanding stays 1; the returned tag is the older one.
- rvalid with nothing outstanding → no res_valid_o, err_o=1 and sticky.
- rst_ni low while in REQ with one outstanding → all outputs at reset values immediately; a later rvalid sets err_o.
